// File: rtl/pixel_shuffle_out.sv
// pixel_shuffle_out: depth-to-space stage. Buffers one LR row of SCALE*SCALE
// channel pixels and replays it as SCALE HR rows of single pixels with
// sof/eol/eof markers. Optional macro PIXEL_SHUFFLE_PINGPONG_EN adds a second
// row bank so one bank fills while the other drains.
module pixel_shuffle_out #(
    parameter int DATA_WIDTH = 8,
    parameter int SCALE      = 3,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_pixel [0:SCALE*SCALE-1],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
);
    localparam int CHANNELS = SCALE * SCALE;
`ifdef PIXEL_SHUFFLE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int SW  = (SCALE      > 1) ? $clog2(SCALE)      : 1;
    localparam int HW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CHW = (CHANNELS   > 1) ? $clog2(CHANNELS)   : 1;

    // Per-bank state: FILL accepts LR pixels, DRAIN holds a complete row
    // that is waiting for or undergoing HR emission.
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
    localparam logic [HW-1:0] H_LAST = HW'(IMG_HEIGHT - 1);

    logic [DATA_WIDTH-1:0] r_buf [0:NB-1][0:IMG_WIDTH-1][0:CHANNELS-1];
    logic [0:0]            r_bank_st [0:NB-1];
    logic                  r_wbank;
    logic                  r_rbank;
    logic                  r_run;
    logic [CW-1:0]         r_in_col;
    logic [HW-1:0]         r_lr_row;
    logic [SW-1:0]         r_r;
    logic [CW-1:0]         r_c;
    logic [SW-1:0]         r_s;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_pixel;
    logic                  r_sof;
    logic                  r_eol;
    logic                  r_eof;

    logic                  w_in_fire;
    logic                  w_fill_done;
    logic                  w_out_fire;
    logic                  w_at_last;
    logic                  w_last_out;
    logic                  w_nbank;
    logic                  w_pend;
    logic                  w_start;
    logic                  w_bypass;
    logic                  w_rdbank;
    logic [HW-1:0]         w_lr_inc;
    logic [HW-1:0]         w_nrow;
    logic [SW-1:0]         w_nr;
    logic [CW-1:0]         w_nc;
    logic [SW-1:0]         w_ns;
    logic [CHW-1:0]        w_nch;
    logic [DATA_WIDTH-1:0] w_npix;

    function automatic logic bank_nxt(input logic b);
        return (NB == 2) ? ~b : 1'b0;
    endfunction

    assign in_ready    = r_run && (r_bank_st[r_wbank] == ST_FILL);
    assign w_in_fire   = in_valid && in_ready;
    assign w_fill_done = w_in_fire && (r_in_col == C_LAST);
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_at_last   = (r_r == S_LAST) && (r_c == C_LAST) && (r_s == S_LAST);
    assign w_last_out  = w_out_fire && w_at_last;
    assign w_lr_inc    = (r_lr_row == H_LAST) ? '0 : r_lr_row + 1'b1;

    // The next row to drain is the bank after the active one; a row whose
    // last LR pixel arrives this cycle counts as ready so HR output starts
    // on the following cycle.
    assign w_nbank  = r_out_valid ? bank_nxt(r_rbank) : r_rbank;
    assign w_pend   = ((r_bank_st[w_nbank] == ST_DRAIN) && !(r_out_valid && (w_nbank == r_rbank)))
                   || (w_fill_done && (r_wbank == w_nbank));
    assign w_start  = (!r_out_valid || w_last_out) && w_pend;
    assign w_bypass = (IMG_WIDTH == 1) && w_start && w_fill_done && (r_wbank == w_nbank);

    // Position, bank and marker values for the pixel loaded into the output register next.
    always_comb begin
        w_nr     = r_r;
        w_nc     = r_c;
        w_ns     = r_s;
        w_nrow   = r_lr_row;
        w_rdbank = r_rbank;
        if (w_start) begin
            w_nr     = '0;
            w_nc     = '0;
            w_ns     = '0;
            w_nrow   = r_out_valid ? w_lr_inc : r_lr_row;
            w_rdbank = w_nbank;
        end else if (r_s != S_LAST) begin
            w_ns = r_s + 1'b1;
        end else begin
            w_ns = '0;
            if (r_c != C_LAST) begin
                w_nc = r_c + 1'b1;
            end else begin
                w_nc = '0;
                w_nr = r_r + 1'b1;
            end
        end
        w_nch  = CHW'(CHW'(w_nr) * CHW'(SCALE)) + CHW'(w_ns);
        w_npix = w_bypass ? in_pixel[w_nch] : r_buf[w_rdbank][w_nc][w_nch];
    end

    // Row buffer write; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_wbank][r_in_col] <= in_pixel;
        end
    end

    // Fill-side bookkeeping: column counter, bank states and bank pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run    <= 1'b0;
            r_in_col <= '0;
            r_wbank  <= 1'b0;
            r_rbank  <= 1'b0;
            r_lr_row <= '0;
            for (int unsigned b = 0; b < NB; b++) begin
                r_bank_st[b] <= ST_FILL;
            end
        end else begin
            r_run <= 1'b1;
            if (w_in_fire) begin
                r_in_col <= w_fill_done ? '0 : r_in_col + 1'b1;
            end
            if (w_fill_done) begin
                r_wbank <= bank_nxt(r_wbank);
            end
            if (w_start) begin
                r_rbank <= w_nbank;
            end else if (w_last_out) begin
                r_rbank <= bank_nxt(r_rbank);
            end
            if (w_last_out) begin
                r_lr_row <= w_lr_inc;
            end
            for (int unsigned b = 0; b < NB; b++) begin
                if (w_fill_done && (r_wbank == 1'(b))) begin
                    r_bank_st[b] <= ST_DRAIN;
                end else if (w_last_out && (r_rbank == 1'(b))) begin
                    r_bank_st[b] <= ST_FILL;
                end
            end
        end
    end

    // Registered HR output: loads on drain start or on each accepted pixel, holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_r         <= '0;
            r_c         <= '0;
            r_s         <= '0;
        end else if (w_start || (w_out_fire && !w_at_last)) begin
            r_out_valid <= 1'b1;
            r_out_pixel <= w_npix;
            r_r         <= w_nr;
            r_c         <= w_nc;
            r_s         <= w_ns;
            r_sof       <= (w_nrow == '0) && (w_nr == '0) && (w_nc == '0) && (w_ns == '0);
            r_eol       <= (w_nc == C_LAST) && (w_ns == S_LAST);
            r_eof       <= (w_nc == C_LAST) && (w_ns == S_LAST) && (w_nr == S_LAST) && (w_nrow == H_LAST);
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_r         <= '0;
            r_c         <= '0;
            r_s         <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_sof   = r_sof;
    assign out_eol   = r_eol;
    assign out_eof   = r_eof;

endmodule

// File: tb/tb_pixel_shuffle_out.sv
// Testbench for pixel_shuffle_out with W=2, H=2, SCALE=3. Expected HR streams
// come from a flat-index reference model (division/modulo on the HR raster
// position) kept in a queue.
module tb_pixel_shuffle_out;
    localparam int W  = 2;
    localparam int H  = 2;
    localparam int S  = 3;
    localparam int CH = S * S;
    localparam int NOUT = S * S * W;
`ifdef PIXEL_SHUFFLE_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_pixel [0:CH-1];
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;

    int   checks;
    int   errors;
    int   m_row;
    exp_t q[$];
    logic [7:0] m_px [0:1][0:W-1][0:CH-1];

    pixel_shuffle_out #(
        .DATA_WIDTH(8),
        .SCALE     (S),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_pixel (in_pixel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_pixel(out_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_eof  (out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic gen_row(input int slot, input int fixed);
        for (int c = 0; c < W; c++) begin
            for (int k = 0; k < CH; k++) begin
                if (fixed != 0) m_px[slot][c][k] = 8'((c + 1) * 10 + k);
                else            m_px[slot][c][k] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // HR raster index k -> sub-row k/(S*W), LR column x/S, sub-column x%S.
    task automatic push_model(input int slot);
        for (int k = 0; k < NOUT; k++) begin
            int   sub;
            int   x;
            exp_t e;
            sub   = k / (S * W);
            x     = k % (S * W);
            e.pix = m_px[slot][x / S][sub * S + (x % S)];
            e.eol = (x == S * W - 1);
            e.sof = (m_row == 0) && (k == 0);
            e.eof = e.eol && (sub == S - 1) && (m_row == H - 1);
            q.push_back(e);
        end
        m_row = (m_row + 1) % H;
    endtask

    task automatic send_row(input int slot, input int gaps);
        int   col;
        int   cyc;
        logic fire;
        col = 0;
        cyc = 0;
        while (col < W && cyc < 300) begin
            for (int k = 0; k < CH; k++) in_pixel[k] = m_px[slot][col][k];
            in_valid = (gaps == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) col++;
        end
        in_valid = 1'b0;
        if (col < W) begin
            checks++; errors++;
            $display("FAIL send_timeout: accepted %0d of %0d LR pixels", col, W);
        end
    endtask

    // mode: 0 always ready, 1 toggling 1,0,1,0, 2 random.
    // ir_mode: 0 no in_ready check, 1 every valid cycle, 2 first output only.
    task automatic collect(input int n, input int mode, input int ir_mode, output int bubbles);
        int         got;
        int         cyc;
        logic       p_stall;
        logic [7:0] p_pix;
        logic [2:0] p_mk;
        exp_t       e;
        got = 0; cyc = 0; p_stall = 1'b0; bubbles = 0; p_pix = '0; p_mk = '0;
        while (got < n && cyc < 2000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (p_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_pixel !== p_pix || {out_sof, out_eol, out_eof} !== p_mk) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b pix=%0d mk=%b, want v=1 pix=%0d mk=%b",
                             out_valid, out_pixel, {out_sof, out_eol, out_eof}, p_pix, p_mk);
                end
            end
            if (out_valid === 1'b1 && (ir_mode == 1 || (ir_mode == 2 && got == 0))) begin
                checks++;
                if (in_ready !== PP) begin
                    errors++;
                    $display("FAIL in_ready_drain: got %b want %b at output %0d", in_ready, PP, got);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output: got pix=%0d with no expected output", out_pixel);
                end else begin
                    e = q.pop_front();
                    if (out_pixel !== e.pix || out_sof !== e.sof || out_eol !== e.eol || out_eof !== e.eof) begin
                        errors++;
                        $display("FAIL hr_pixel[%0d]: got pix=%0d sof=%b eol=%b eof=%b, want pix=%0d sof=%b eol=%b eof=%b",
                                 got, out_pixel, out_sof, out_eol, out_eof, e.pix, e.sof, e.eol, e.eof);
                    end
                end
                got++;
            end else if (got > 0 && out_valid !== 1'b1) begin
                bubbles++;
            end
            p_stall = (out_valid === 1'b1) && !out_ready;
            p_pix   = out_pixel;
            p_mk    = {out_sof, out_eol, out_eof};
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (got < n) begin
            checks++; errors++;
            $display("FAIL collect_timeout: got %0d of %0d HR pixels", got, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_pixel !== 8'd0 ||
            {out_sof, out_eol, out_eof} !== 3'b000) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b v=%b pix=%0d mk=%b, want 0 0 0 000",
                     in_ready, out_valid, out_pixel, {out_sof, out_eol, out_eof});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
        end
        m_row = 0;
    endtask

    task automatic test_basic_row();
        int b;
        gen_row(0, 1);
        push_model(0);
        send_row(0, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_latency: got out_valid=%b, want 1", out_valid);
        end
        collect(NOUT, 0, 1, b);
    endtask

    task automatic test_stall();
        int b;
        gen_row(0, 0);
        push_model(0);
        send_row(0, 0);
        collect(NOUT, 1, 0, b);
    endtask

    task automatic test_frame();
        int b;
        for (int r = 0; r < 2 * H; r++) begin
            gen_row(0, 0);
            push_model(0);
            send_row(0, 1);
            collect(NOUT, 2, 0, b);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        gen_row(0, 0);
        push_model(0);
        send_row(0, 0);
        collect(5, 0, 0, b);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got v=%b rdy=%b, want 0 0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got out_valid=%b, want 0", out_valid);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got in_ready=%b, want 1", in_ready);
        end
        q.delete();
        m_row = 0;
        gen_row(0, 0);
        push_model(0);
        send_row(0, 0);
        collect(NOUT, 0, 0, b);
    endtask

    task automatic test_in_gaps();
        int   b;
        int   col;
        logic fire;
        int   pat [4] = '{1, 0, 0, 1};
        gen_row(0, 0);
        push_model(0);
        col = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < CH; k++) in_pixel[k] = m_px[0][col][k];
            in_valid = (pat[i] == 1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_early_drain: got out_valid=%b at step %0d, want 0", out_valid, i);
            end
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire && col < W - 1) col++;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_first_valid: got out_valid=%b, want 1", out_valid);
        end
        collect(NOUT, 2, 0, b);
    endtask

    task automatic test_back_to_back();
        int bub;
        gen_row(0, 0);
        gen_row(1, 0);
        push_model(0);
        push_model(1);
        fork
            begin
                send_row(0, 0);
                send_row(1, 0);
            end
            begin
                collect(2 * NOUT, 0, 2, bub);
            end
        join
        checks++;
        if (bub != (PP ? 0 : W)) begin
            errors++;
            $display("FAIL b2b_bubbles: got %0d idle cycles between rows, want %0d", bub, PP ? 0 : W);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: got %0d expected pixels unconsumed, want 0", q.size());
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_row     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < CH; k++) in_pixel[k] = '0;
        test_reset();
        test_basic_row();
        test_stall();
        test_frame();
        test_reset_mid();
        test_in_gaps();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
